// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared PC-generator types, default vectors and clog2 helper
// Revision 1.0
// ============================================================================
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } pc_state_e;

  localparam logic [31:0] c_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] c_EXC_VEC   = 32'h0000_0080;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_unit_if.sv
`default_nettype none
// ============================================================================
// pc_gen_unit_if : redirect, RAS and fetch-handshake signals of the PC generator
// Revision 1.0
// ============================================================================
interface pc_gen_unit_if #(
  parameter int WIDTH_I = 32
);
  logic               if_ready;
  logic               stall;
  logic               exc_req;
  logic               br_taken;
  logic [WIDTH_I-1:0] br_target;
  logic               call_push;
  logic [WIDTH_I-1:0] call_ret_addr;
  logic               ret_pop;
  logic [WIDTH_I-1:0] pc_addr;
  logic               pc_valid;
  logic [WIDTH_I-1:0] pc_next;
  logic               flush;
  logic               ras_empty;
  logic               ras_full;

  // Pipeline / fetch side
  modport master (
    output if_ready, stall, exc_req, br_taken, br_target,
           call_push, call_ret_addr, ret_pop,
    input  pc_addr, pc_valid, pc_next, flush, ras_empty, ras_full
  );

  // PC generator side
  modport slave (
    input  if_ready, stall, exc_req, br_taken, br_target,
           call_push, call_ret_addr, ret_pop,
    output pc_addr, pc_valid, pc_next, flush, ras_empty, ras_full
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen_unit_ras.sv
`default_nettype none
// ============================================================================
// pc_ras : circular return-address stack, oldest entry overwritten when full
// Revision 1.0
// ============================================================================
module pc_ras
  import cpu_pkg::*;
#(
  parameter int WIDTH_I = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH_I-1:0] push_data,
  output logic [WIDTH_I-1:0] top_data,
  output logic               empty,
  output logic               full
);

  localparam int c_PTR_W = clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [WIDTH_I-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_top;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] w_top_inc;
  logic [c_PTR_W-1:0] w_top_dec;

  assign w_top_inc = r_top + c_PTR_W'(1);
  assign w_top_dec = r_top - c_PTR_W'(1);
  assign top_data  = r_mem[r_top];
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_DEPTH_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_top   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push && pop) begin
      // Return consumes the top while the call refills it: depth unchanged
      r_mem[r_top] <= push_data;
    end else if (push) begin
      r_mem[w_top_inc] <= push_data;
      r_top            <= w_top_inc;
      if (!full) r_count <= r_count + c_CNT_W'(1);
    end else if (pop && !empty) begin
      r_top   <= w_top_dec;
      r_count <= r_count - c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen_unit.sv
`default_nettype none
// ============================================================================
// pc_gen_unit : IF-stage program counter with prioritised redirects and RAS
// Revision 1.0
// ============================================================================
module pc_gen_unit
  import cpu_pkg::*;
#(
  parameter int                 WIDTH_I   = 32,
  parameter int                 PC_STEP   = 4,
  parameter logic [WIDTH_I-1:0] RESET_VEC = WIDTH_I'(c_RESET_VEC),
  parameter logic [WIDTH_I-1:0] EXC_VEC   = WIDTH_I'(c_EXC_VEC),
  parameter int                 RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_gen_unit_if.slave  bus
);

  localparam logic [WIDTH_I-1:0] c_STEP       = WIDTH_I'(PC_STEP);
  localparam logic [WIDTH_I-1:0] c_ALIGN_MASK = ~(c_STEP - WIDTH_I'(1));

  pc_state_e          r_state;
  pc_state_e          w_state_nxt;
  logic [WIDTH_I-1:0] r_pc;
  logic               r_flush;

  logic               w_ras_empty;
  logic               w_ras_full;
  logic [WIDTH_I-1:0] w_ras_top;

  logic               w_take_exc;
  logic               w_take_br;
  logic               w_take_ret;
  logic               w_redirect;
  logic [WIDTH_I-1:0] w_target;
  logic [WIDTH_I-1:0] w_pc_next;
  logic               w_advance;

  assign w_pc_next  = r_pc + c_STEP;

  // Fixed priority: exception > branch > return (only when a return address exists)
  assign w_take_exc = bus.exc_req;
  assign w_take_br  = !bus.exc_req && bus.br_taken;
  assign w_take_ret = !bus.exc_req && !bus.br_taken && bus.ret_pop && !w_ras_empty;
  assign w_redirect = w_take_exc || w_take_br || w_take_ret;

  always_comb begin
    w_target = w_ras_top;
    if (w_take_exc)     w_target = EXC_VEC;
    else if (w_take_br) w_target = bus.br_target;
    w_target = w_target & c_ALIGN_MASK;
  end

  assign w_advance = (r_state == ST_RUN) && bus.if_ready && !bus.stall;

  always_comb begin
    w_state_nxt = r_state;
    if (w_redirect) begin
      w_state_nxt = ST_BUBBLE;
    end else begin
      case (r_state)
        ST_BOOT:   w_state_nxt = ST_RUN;
        ST_BUBBLE: w_state_nxt = ST_RUN;
        ST_RUN:    w_state_nxt = ST_RUN;
        default:   w_state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VEC;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_redirect;
      if (w_redirect)     r_pc <= w_target;
      else if (w_advance) r_pc <= w_pc_next;
    end
  end

  pc_ras #(
    .WIDTH_I (WIDTH_I),
    .DEPTH   (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_take_exc),
    .push      (bus.call_push && !w_take_exc),
    .pop       (w_take_ret),
    .push_data (bus.call_ret_addr),
    .top_data  (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full)
  );

  assign bus.pc_addr   = r_pc;
  assign bus.pc_valid  = (r_state == ST_RUN);
  assign bus.pc_next   = w_pc_next;
  assign bus.flush     = r_flush;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_gen_unit : directed + randomized bench against a queue-based model
// Revision 1.0
// ============================================================================
module tb_pc_gen_unit;

  localparam int          c_DEPTH = 4;
  localparam logic [31:0] c_EXC   = 32'h0000_0080;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pc_gen_unit_if #(.WIDTH_I(32)) bus ();

  pc_gen_unit #(
    .WIDTH_I   (32),
    .PC_STEP   (4),
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (c_EXC),
    .RAS_DEPTH (c_DEPTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural PC, fetch-valid flag and RAS as a plain queue
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_flush;
  logic [31:0] m_ras [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_flush = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_push(input logic [31:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > c_DEPTH) void'(m_ras.pop_front());
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    redir = 1'b0;
    tgt   = 32'h0;
    if (bus.exc_req) begin
      redir = 1'b1;
      tgt   = c_EXC;
      m_ras.delete();
    end else if (bus.br_taken) begin
      redir = 1'b1;
      tgt   = bus.br_target;
      if (bus.call_push) model_push(bus.call_ret_addr);
    end else if (bus.ret_pop && m_ras.size() > 0) begin
      redir = 1'b1;
      tgt   = m_ras[m_ras.size()-1];
      if (bus.call_push) m_ras[m_ras.size()-1] = bus.call_ret_addr;
      else void'(m_ras.pop_back());
    end else if (bus.call_push) begin
      model_push(bus.call_ret_addr);
    end
    if (redir) m_pc = {tgt[31:2], 2'b00};
    else if (m_valid && bus.if_ready && !bus.stall) m_pc = m_pc + 32'd4;
    m_flush = redir;
    m_valid = !redir;
  endtask

  task automatic check_all();
    chk("pc_addr",   bus.pc_addr,          m_pc);
    chk("pc_valid",  32'(bus.pc_valid),    32'(m_valid));
    chk("pc_next",   bus.pc_next,          m_pc + 32'd4);
    chk("flush",     32'(bus.flush),       32'(m_flush));
    chk("ras_empty", 32'(bus.ras_empty),   32'(m_ras.size() == 0));
    chk("ras_full",  32'(bus.ras_full),    32'(m_ras.size() == c_DEPTH));
  endtask

  // Called at a negedge with inputs already driven
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic st, input logic rdy, input logic exc, input logic br,
                       input logic [31:0] tgt, input logic push, input logic [31:0] ra,
                       input logic pop);
    bus.stall         = st;
    bus.if_ready      = rdy;
    bus.exc_req       = exc;
    bus.br_taken      = br;
    bus.br_target     = tgt;
    bus.call_push     = push;
    bus.call_ret_addr = ra;
    bus.ret_pop       = pop;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0,
            $urandom_range(7) == 0, $urandom, $urandom_range(3) == 0, $urandom,
            $urandom_range(2) == 0);
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Free run from reset: one BOOT cycle, then 0x0, 0x4, 0x8, 0xC, 0x10
    tick();
    chk("boot_pc0", bus.pc_addr, 32'h0);
    repeat (3) tick();
    chk("seq_pc_c", bus.pc_addr, 32'hC);
    tick();

    // Stall and backpressure hold 0x10 with valid asserted
    bus.stall = 1'b1;
    repeat (3) tick();
    chk("stall_hold", bus.pc_addr, 32'h10);
    chk("stall_valid", 32'(bus.pc_valid), 32'd1);
    bus.stall    = 1'b0;
    bus.if_ready = 1'b0;
    repeat (2) tick();
    chk("nrdy_hold", bus.pc_addr, 32'h10);
    bus.if_ready = 1'b1;
    tick();
    chk("resume_14", bus.pc_addr, 32'h14);

    // Branch while stalled, misaligned target
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0);
    tick();
    chk("br_pc", bus.pc_addr, 32'h200);
    chk("br_flush", 32'(bus.flush), 32'd1);
    idle();
    tick();
    chk("br_flush_end", 32'(bus.flush), 32'd0);
    tick();
    chk("br_resume", bus.pc_addr, 32'h204);

    // Everything at once: exception wins and empties the RAS
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h444, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h555, 1'b1);
    tick();
    chk("exc_pc", bus.pc_addr, 32'h80);
    chk("exc_ras_empty", 32'(bus.ras_empty), 32'd1);

    // Overflow: five pushes into four entries, then four returns and one spare
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.call_push     = 1'b1;
      bus.call_ret_addr = 32'h100 + 32'(4 * i);
      tick();
    end
    chk("ras_full5", 32'(bus.ras_full), 32'd1);
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.ret_pop = 1'b1;
      tick();
      chk("ret_pc", bus.pc_addr, 32'h110 - 32'(4 * i));
    end
    tick();
    chk("ret_empty_flush", 32'(bus.flush), 32'd0);
    idle();
    tick();

    // Wrap at the top of the address space
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    tick();
    chk("wrap_top", bus.pc_addr, 32'hFFFF_FFFC);
    chk("wrap_next", bus.pc_next, 32'h0);
    idle();
    repeat (2) tick();
    chk("wrap_zero", bus.pc_addr, 32'h0);

    random_run(400);

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc_addr, 32'h0);
    chk("async_valid", 32'(bus.pc_valid), 32'd0);
    model_reset();
    idle();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    random_run(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
